// File: rtl/decompress_block_pkg.sv
// Shared constants and helpers for the dequantizer / inverse DCT decode path.
// The tables are common with the forward compression path.
package decompress_block_pkg;

  localparam int BLOCK_SIZE  = 8;
  localparam int COEFF_WIDTH = 16;
  localparam int INT_WIDTH   = 24;
  localparam int COS_FRAC    = 14;
  localparam int PIX_WIDTH   = 9;
  localparam int MUL_WIDTH   = INT_WIDTH + 16;
  localparam int ACC_WIDTH   = INT_WIDTH + 16 + 3;
  localparam int DQ_WIDTH    = COEFF_WIDTH + 9;

  typedef enum logic [1:0] {IDLE, LOAD, ROW, COL} state_t;

  localparam logic [7:0] QUANT_TABLE [BLOCK_SIZE][BLOCK_SIZE] = '{
    '{8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61},
    '{8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55},
    '{8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56},
    '{8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62},
    '{8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77},
    '{8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92},
    '{8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101},
    '{8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99}
  };

  // COS_TABLE[k][n] = a(k) * cos((2n+1)k*pi/16) in Q1.14
  localparam logic signed [15:0] COS_TABLE [BLOCK_SIZE][BLOCK_SIZE] = '{
    '{ 16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793},
    '{ 16'sd8035,  16'sd6811,  16'sd4551,  16'sd1598, -16'sd1598, -16'sd4551, -16'sd6811, -16'sd8035},
    '{ 16'sd7568,  16'sd3135, -16'sd3135, -16'sd7568, -16'sd7568, -16'sd3135,  16'sd3135,  16'sd7568},
    '{ 16'sd6811, -16'sd1598, -16'sd8035, -16'sd4551,  16'sd4551,  16'sd8035,  16'sd1598, -16'sd6811},
    '{ 16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,  16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793},
    '{ 16'sd4551, -16'sd8035,  16'sd1598,  16'sd6811, -16'sd6811, -16'sd1598,  16'sd8035, -16'sd4551},
    '{ 16'sd3135, -16'sd7568,  16'sd7568, -16'sd3135, -16'sd3135,  16'sd7568, -16'sd7568,  16'sd3135},
    '{ 16'sd1598, -16'sd4551,  16'sd6811, -16'sd8035,  16'sd8035, -16'sd6811,  16'sd4551, -16'sd1598}
  };

  localparam logic signed [DQ_WIDTH-1:0]  DQ_HI  = DQ_WIDTH'(2 ** (INT_WIDTH - 1) - 1);
  localparam logic signed [DQ_WIDTH-1:0]  DQ_LO  = ~DQ_HI;
  localparam logic signed [INT_WIDTH-1:0] PIX_HI = INT_WIDTH'(2 ** (PIX_WIDTH - 1) - 1);
  localparam logic signed [INT_WIDTH-1:0] PIX_LO = ~PIX_HI;

  // Quant entry is unsigned, so it is zero-extended before the signed multiply.
  function automatic logic signed [INT_WIDTH-1:0] dequant(input logic signed [COEFF_WIDTH-1:0] c,
                                                          input logic [7:0] q);
    logic signed [DQ_WIDTH-1:0] p;
    p = DQ_WIDTH'(c) * DQ_WIDTH'($signed({1'b0, q}));
    if (p > DQ_HI)      return INT_WIDTH'(DQ_HI);
    else if (p < DQ_LO) return INT_WIDTH'(DQ_LO);
    else                return INT_WIDTH'(p);
  endfunction

  function automatic logic signed [PIX_WIDTH-1:0] sat_pix(input logic signed [INT_WIDTH-1:0] v);
    if (v > PIX_HI)      return PIX_WIDTH'(PIX_HI);
    else if (v < PIX_LO) return PIX_WIDTH'(PIX_LO);
    else                 return PIX_WIDTH'(v);
  endfunction

endpackage

// File: rtl/decompress_block_if.sv
// Block-level handshake between the coefficient source and the decoder.
interface decompress_block_if;
  import decompress_block_pkg::*;

  logic                          start_block;
  logic signed [COEFF_WIDTH-1:0] coeffs_in [BLOCK_SIZE][BLOCK_SIZE];
  logic                          busy;
  logic signed [PIX_WIDTH-1:0]   block_out [BLOCK_SIZE][BLOCK_SIZE];
  logic                          block_done;

  modport master (output start_block, coeffs_in, input busy, block_out, block_done);
  modport slave  (input start_block, coeffs_in, output busy, block_out, block_done);

endinterface

// File: rtl/decompress_block_idct.sv
// Combinational 8-point inverse DCT with round-half-up and output saturation.
module idct_1d_8
  import decompress_block_pkg::*;
#(
  parameter int OUT_WIDTH = INT_WIDTH
) (
  input  logic signed [INT_WIDTH-1:0] x [BLOCK_SIZE],
  output logic signed [OUT_WIDTH-1:0] y [BLOCK_SIZE]
);

  localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS = ACC_WIDTH'(2 ** (COS_FRAC - 1));
  localparam logic signed [ACC_WIDTH-1:0] OUT_HI     = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_LO     = ~OUT_HI;

  logic signed [ACC_WIDTH-1:0] acc   [BLOCK_SIZE];
  logic signed [ACC_WIDTH-1:0] rnd_v [BLOCK_SIZE];

  always_comb begin
    for (int n = 0; n < BLOCK_SIZE; n++) begin
      acc[n] = '0;
      for (int k = 0; k < BLOCK_SIZE; k++) begin
        acc[n] = acc[n] + ACC_WIDTH'(MUL_WIDTH'(x[k]) * MUL_WIDTH'(COS_TABLE[k][n]));
      end
      rnd_v[n] = (acc[n] + ROUND_BIAS) >>> COS_FRAC;
      if (rnd_v[n] > OUT_HI)      y[n] = OUT_WIDTH'(OUT_HI);
      else if (rnd_v[n] < OUT_LO) y[n] = OUT_WIDTH'(OUT_LO);
      else                        y[n] = OUT_WIDTH'(rnd_v[n]);
    end
  end

endmodule

// File: rtl/decompress_block.sv
// Dequantize one 8x8 block and reconstruct pixels with a row-then-column IDCT.
//   state | meaning
//   IDLE  | waiting for start_block; dequant registered on acceptance
//   LOAD  | one-cycle slot letting the dequant registers settle
//   ROW   | row pass, idx selects the dq row, result into tmp row
//   COL   | column pass, idx selects the tmp column, result into stg column
module decompress_block
  import decompress_block_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  decompress_block_if.slave bus
);

  state_t                      state;
  logic [2:0]                  idx;
  logic signed [INT_WIDTH-1:0] dq  [BLOCK_SIZE][BLOCK_SIZE];
  logic signed [INT_WIDTH-1:0] tmp [BLOCK_SIZE][BLOCK_SIZE];
  logic signed [PIX_WIDTH-1:0] stg [BLOCK_SIZE][BLOCK_SIZE];
  logic signed [INT_WIDTH-1:0] pass_in  [BLOCK_SIZE];
  logic signed [INT_WIDTH-1:0] pass_out [BLOCK_SIZE];

  // One transform shared by both passes; the row pass reads dq, the column pass reads tmp.
  always_comb begin
    for (int k = 0; k < BLOCK_SIZE; k++) begin
      pass_in[k] = (state == COL) ? tmp[k][idx] : dq[idx][k];
    end
  end

  idct_1d_8 #(.OUT_WIDTH(INT_WIDTH)) u_idct (
    .x (pass_in),
    .y (pass_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      bus.busy       <= 1'b0;
      bus.block_done <= 1'b0;
      for (int u = 0; u < BLOCK_SIZE; u++) begin
        for (int v = 0; v < BLOCK_SIZE; v++) begin
          dq[u][v]            <= '0;
          tmp[u][v]           <= '0;
          stg[u][v]           <= '0;
          bus.block_out[u][v] <= '0;
        end
      end
    end else begin
      bus.block_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_block) begin
            for (int u = 0; u < BLOCK_SIZE; u++) begin
              for (int v = 0; v < BLOCK_SIZE; v++) begin
                dq[u][v] <= dequant(bus.coeffs_in[u][v], QUANT_TABLE[u][v]);
              end
            end
            bus.busy <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          idx   <= '0;
          state <= ROW;
        end
        ROW: begin
          for (int n = 0; n < BLOCK_SIZE; n++) tmp[idx][n] <= pass_out[n];
          idx <= idx + 3'd1;
          if (idx == 3'd7) state <= COL;
        end
        COL: begin
          for (int n = 0; n < BLOCK_SIZE; n++) stg[n][idx] <= sat_pix(pass_out[n]);
          idx <= idx + 3'd1;
          if (idx == 3'd7) begin
            // Last column bypasses stg so the block publishes on this edge.
            for (int u = 0; u < BLOCK_SIZE; u++) begin
              for (int v = 0; v < BLOCK_SIZE - 1; v++) bus.block_out[u][v] <= stg[u][v];
              bus.block_out[u][BLOCK_SIZE-1] <= sat_pix(pass_out[u]);
            end
            bus.block_done <= 1'b1;
            bus.busy       <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
